serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// serial_add_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Bit-serial-by-nibble adder. One 4-bit ripple_adder is time-shared across
//   NIBBLES slices of the operands, one slice per clock. A small three-state
//   FSM (IDLE -> RUN -> DONE -> IDLE) sequences operand capture, slice
//   iteration and result presentation.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The producer holds valid (and data) until that edge; ready may depend on
//   state only, never combinationally on valid.
//
// Optional feature:
//   SERIAL_ADD_CTRL_SUB_MODE_EN - when defined, adds input port 'sub'. With
//   sub=1 at accept the block computes A-B (B inverted, carry-in forced to 1,
//   cin ignored); cout=1 then means "no borrow". Undefined: add only.
//
// Ports:
//   clk        in   1  single clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  operands valid
//   in_ready   out  1  block accepts operands (state IDLE)
//   a, b       in   W  operands, W = 4*NIBBLES
//   cin        in   1  carry-in
//   sub        in   1  subtract select (only with SERIAL_ADD_CTRL_SUB_MODE_EN)
//   out_valid  out  1  result valid (state DONE)
//   out_ready  in   1  consumer takes result
//   sum        out  W  result, modulo 2^W
//   cout       out  1  carry out of MSB
//   ovf        out  1  signed overflow (carry into MSB XOR cout)
//   busy       out  1  high in RUN
//   dbg_state  out  2  current FSM state encoding, for observation
// ============================================================================

// ----------------------------------------------------------------------------
// ripple_adder: 4-bit ripple-carry adder. Also exposes the carry into bit 3
// so the caller can derive signed overflow for the most significant slice.
// ----------------------------------------------------------------------------
module ripple_adder (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cin,
   output logic [3:0] o_sum,
   output logic       o_cout,
   output logic       o_c3
);

   // w_c[i] is the carry into bit i; w_c[4] is the carry out.
   logic [4:0] w_c;

   assign w_c[0] = i_cin;

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_fa
         assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
         assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
      end
   endgenerate

   assign o_cout = w_c[4];
   assign o_c3   = w_c[3];

endmodule

// ----------------------------------------------------------------------------
// serial_add_ctrl: top level
// ----------------------------------------------------------------------------
module serial_add_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 cin,
`ifdef SERIAL_ADD_CTRL_SUB_MODE_EN
   input  logic                 sub,
`endif
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout,
   output logic                 ovf,
   output logic                 busy,
   output logic [1:0]           dbg_state
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   state_t             r_state;
   logic [W-1:0]       r_a;
   logic [W-1:0]       r_b;       // already inverted when subtracting
   logic               r_carry;
   logic [IDX_W-1:0]   r_idx;
   logic [W-1:0]       r_sum;
   logic               r_cout;
   logic               r_ovf;

   // -------------------------------------------------------------------------
   // Wires
   // -------------------------------------------------------------------------
   state_t             w_state_nxt;
   logic               w_accept;
   logic               w_run;
   logic               w_last;
   logic               w_sub;
   logic [W-1:0]       w_b_load;
   logic               w_cin_load;
   logic [3:0]         w_a_slice;
   logic [3:0]         w_b_slice;
   logic [3:0]         w_add_sum;
   logic               w_add_cout;
   logic               w_add_c3;

`ifdef SERIAL_ADD_CTRL_SUB_MODE_EN
   assign w_sub = sub;
`else
   assign w_sub = 1'b0;
`endif

   // Subtraction is A + ~B + 1; the inversion is applied once at capture so
   // the RUN datapath is identical for add and subtract.
   assign w_b_load   = w_sub ? ~b : b;
   assign w_cin_load = w_sub ? 1'b1 : cin;

   assign w_accept = (r_state == IDLE) && in_valid;
   assign w_run    = (r_state == RUN);
   assign w_last   = (r_idx == IDX_W'(NIBBLES - 1));

   // Slice select: {idx,2'b00} is idx*4 without widening to 32 bits.
   assign w_a_slice = r_a[{r_idx, 2'b00} +: 4];
   assign w_b_slice = r_b[{r_idx, 2'b00} +: 4];

   // -------------------------------------------------------------------------
   // The single shared adder
   // -------------------------------------------------------------------------
   ripple_adder u_adder (
      .i_a    (w_a_slice),
      .i_b    (w_b_slice),
      .i_cin  (r_carry),
      .o_sum  (w_add_sum),
      .o_cout (w_add_cout),
      .o_c3   (w_add_c3)
   );

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (w_last) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_accept) begin
            // Operands are only captured here, so in_valid in RUN/DONE
            // cannot disturb an operation in flight.
            r_a     <= a;
            r_b     <= w_b_load;
            r_carry <= w_cin_load;
            r_idx   <= '0;
         end else if (w_run) begin
            r_sum[{r_idx, 2'b00} +: 4] <= w_add_sum;
            r_carry                    <= w_add_cout;
            r_idx                      <= r_idx + IDX_W'(1);
            if (w_last) begin
               // cout/ovf change only when the final slice completes, so the
               // previous result's flags stay visible until then.
               r_cout <= w_add_cout;
               r_ovf  <= w_add_c3 ^ w_add_cout;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign in_ready  = (r_state == IDLE);
   assign busy      = (r_state == RUN);
   assign out_valid = (r_state == DONE);
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// tb_serial_add_ctrl
// ----------------------------------------------------------------------------
// Bench for serial_add_ctrl (NIBBLES=4). Expected results come from a
// whole-word arithmetic model and are queued when operands are accepted,
// then popped and compared when out_valid is seen.
// ============================================================================
module tb_serial_add_ctrl;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;
   localparam int MAX_LAT = 20;

   // -------------------------------------------------------------------------
   // Clock / reset
   // -------------------------------------------------------------------------
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // -------------------------------------------------------------------------
   // DUT
   // -------------------------------------------------------------------------
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          cout;
   logic          ovf;
   logic          busy;
   logic [1:0]    dbg_state;

   serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef SERIAL_ADD_CTRL_SUB_MODE_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // -------------------------------------------------------------------------
   // Scoreboard
   // -------------------------------------------------------------------------
   logic [W+1:0] exp_q[$];     // {ovf, cout, sum}
   logic [W+1:0] last_exp;
   int           n_checks;
   int           n_pass;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp,
                  $time);
      end
   endtask

   // Reference model: whole-word arithmetic, overflow from sign rules via the
   // carry into the MSB computed on the lower W-1 bits.
   function automatic logic [W+1:0] model(input logic [W-1:0] ma,
                                          input logic [W-1:0] mb,
                                          input logic mcin, input logic msub);
      logic [W-1:0] bb;
      logic         cc;
      logic [W:0]   full;
      logic [W-1:0] low;
      bb   = msub ? ~mb : mb;
      cc   = msub ? 1'b1 : mcin;
      full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, cc};
      low  = {1'b0, ma[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, cc};
      return {low[W-1] ^ full[W], full[W], full[W-1:0]};
   endfunction

   // -------------------------------------------------------------------------
   // Driver tasks (all entered and left at a falling edge)
   // -------------------------------------------------------------------------
   task automatic drive_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tcin, input logic tsub);
      check("in_ready_before_op", in_ready, 1'b1);
      a        = ta;
      b        = tb;
      cin      = tcin;
      sub      = tsub;
      in_valid = 1'b1;
`ifdef SERIAL_ADD_CTRL_SUB_MODE_EN
      exp_q.push_back(model(ta, tb, tcin, tsub));
`else
      exp_q.push_back(model(ta, tb, tcin, 1'b0));
`endif
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a        = $urandom_range(0, 65535);
      b        = $urandom_range(0, 65535);
      check("busy_after_accept", busy, 1'b1);
   endtask

   // Counts cycles from the accept edge until out_valid, then scores result.
   task automatic wait_result();
      int lat;
      lat = 0;
      while (!out_valid && lat < MAX_LAT) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, NIBBLES);
      check("q_not_empty", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) begin
         last_exp = exp_q.pop_front();
         check("sum",  sum,  last_exp[W-1:0]);
         check("cout", cout, last_exp[W]);
         check("ovf",  ovf,  last_exp[W+1]);
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_after_hs", out_valid, 1'b0);
      check("in_ready_after_hs",  in_ready,  1'b1);
      check("sum_held_in_idle",   sum,       last_exp[W-1:0]);
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tcin, input logic tsub);
      drive_op(ta, tb, tcin, tsub);
      wait_result();
      handshake();
   endtask

   // -------------------------------------------------------------------------
   // Watchdog
   // -------------------------------------------------------------------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // -------------------------------------------------------------------------
   // Main sequence
   // -------------------------------------------------------------------------
   initial begin
      logic ov_seen;
      n_checks  = 0;
      n_pass    = 0;
      last_exp  = '0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy",      busy,      1'b0);
      check("rst_sum",       sum,       '0);
      check("rst_cout",      cout,      1'b0);
      check("rst_ovf",       ovf,       1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_rst", in_ready, 1'b1);

      // Directed vectors
      run_op(16'h1234, 16'h1111, 1'b0, 1'b0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0);
      run_op(16'h8000, 16'h8000, 1'b0, 1'b0);

      // Stall in DONE with in_valid pulsed: result stable, new operands ignored
      drive_op(16'h00FF, 16'h0F01, 1'b0, 1'b0);
      wait_result();
      for (int i = 0; i < 10; i++) begin
         if (i >= 3 && i <= 5) begin
            in_valid = 1'b1;
            a        = 16'hAAAA;
            b        = 16'h5555;
            cin      = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         check("stall_sum",       sum,       last_exp[W-1:0]);
         check("stall_in_ready",  in_ready,  1'b0);
         check("stall_out_valid", out_valid, 1'b1);
      end
      in_valid = 1'b0;
      handshake();
      @(negedge clk);
      check("no_op_after_stall", busy, 1'b0);

      // Random operands
      for (int i = 0; i < 6; i++) begin
         run_op(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                1'($urandom_range(0, 1)), 1'b0);
      end

      // Reset during the 2nd RUN cycle discards the operation
      a        = 16'h1111;
      b        = 16'h2222;
      cin      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrun_rst_out_valid", out_valid, 1'b0);
      check("midrun_rst_busy",      busy,      1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_out_valid", out_valid, 1'b0);
      check("post_rst_sum",       sum,       '0);
      check("post_rst_in_ready",  in_ready,  1'b1);
      ov_seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid || busy) ov_seen = 1'b1;
      end
      check("no_result_after_rst", ov_seen, 1'b0);
      run_op(16'h0001, 16'h0002, 1'b0, 1'b0);

`ifdef SERIAL_ADD_CTRL_SUB_MODE_EN
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
      run_op(16'h0009, 16'h0003, 1'b0, 1'b1);
      run_op(16'h8000, 16'h0001, 1'b1, 1'b1);
`endif

      check("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
